// File: rtl/slot_allocator.sv
// Slot allocator: grants the lowest-index free slot out of 2**WIDTH and
// accepts per-slot releases, flagging frees of slots that are not held.
module slot_allocator #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alloc_req,
   output logic                  alloc_gnt,
   output logic [WIDTH-1:0]      alloc_idx,
   input  logic                  free_vld,
   input  logic [WIDTH-1:0]      free_idx,
   output logic [(1<<WIDTH)-1:0] busy_map,
   output logic [WIDTH:0]        count,
   output logic                  full,
   output logic                  empty,
   output logic                  err_double_free
);

   localparam int N = 1 << WIDTH;
   typedef logic [WIDTH:0] cnt_t;

   logic [N-1:0]     busy_q, busy_d;
   cnt_t             count_q, count_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] sel_idx;
   logic             legal_free;

   // Descending scan so the lowest clear bit is the last one written.
   always_comb begin
      sel_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!busy_q[i]) sel_idx = WIDTH'(i);
      end
   end

   assign full      = (count_q == cnt_t'(N));
   assign empty     = (count_q == '0);
   assign alloc_gnt = alloc_req & ~full;
   assign alloc_idx = sel_idx;

   // NOTE: every combinational output gets a default before any branch,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      busy_d     = busy_q;
      count_d    = count_q;
      legal_free = free_vld &  busy_q[free_idx];
      err_d      = free_vld & ~busy_q[free_idx];
      if (legal_free) busy_d[free_idx] = 1'b0;
      // sel_idx is a currently free slot, so it never collides with free_idx.
      if (alloc_gnt) busy_d[sel_idx] = 1'b1;
      if (alloc_gnt && !legal_free)      count_d = count_q + cnt_t'(1);
      else if (legal_free && !alloc_gnt) count_d = count_q - cnt_t'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign busy_map        = busy_q;
   assign count           = count_q;
   assign err_double_free = err_q;

endmodule
